// File: rtl/vlsu_txn_issuer.sv
// vlsu_txn_issuer
//   Turns one nibble-addressed, page-bounded VLSU fragment into a single AXI4
//   AR (load) or AW (store) beat. It also queues a per-transaction descriptor
//   for the data-path aligners and keeps outstanding counts per direction.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   frag_*                     fragment request (valid/ready handshake)
//   ar_* / aw_*                AXI4 read / write address channels
//   r_last_hs_i, b_hs_i        completion pulses (last R beat, B response)
//   info_*                     descriptor FIFO head (valid/ready handshake)
//   idle_o                     nothing in flight, nothing queued
module vlsu_txn_issuer #(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 128,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned InfoDepth      = 4,
  localparam int unsigned DWB           = DataWidth / 8,
  localparam int unsigned OffW          = $clog2(DWB)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 frag_valid_i,
  output logic                 frag_ready_o,
  input  logic [AddrWidth:0]   frag_addr_i,
  input  logic [13:0]          frag_nbs_i,
  input  logic                 frag_is_load_i,
  input  logic [IdWidth-1:0]   frag_id_i,
  input  logic                 frag_last_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  output logic [2:0]           ar_size_o,
  output logic [1:0]           ar_burst_o,
  output logic [IdWidth-1:0]   ar_id_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [7:0]           aw_len_o,
  output logic [2:0]           aw_size_o,
  output logic [1:0]           aw_burst_o,
  output logic [IdWidth-1:0]   aw_id_o,
  input  logic                 r_last_hs_i,
  input  logic                 b_hs_i,
  output logic                 info_valid_o,
  input  logic                 info_ready_i,
  output logic [OffW-1:0]      info_off_o,
  output logic [13:0]          info_nbs_o,
  output logic                 info_nib_odd_o,
  output logic                 info_last_o,
  output logic                 info_is_load_o,
  output logic                 idle_o
);

  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW  = (InfoDepth > 1) ? $clog2(InfoDepth) : 1;
  localparam int unsigned FcntW = $clog2(InfoDepth + 1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [IdWidth-1:0]   id;
  } ax_t;

  typedef struct packed {
    logic [OffW-1:0] off;
    logic [13:0]     nbs;
    logic            nib_odd;
    logic            last;
    logic            is_load;
  } info_t;

  // Saturating up/down count; a decrement at zero is dropped.
  function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    return cnt + CntW'(inc) - CntW'(dec && (cnt != '0));
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(InfoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Fragment -> AXI burst arithmetic
  logic [AddrWidth-1:0] byte_addr;
  logic [14:0]          bytes;
  logic [OffW-1:0]      off;
  logic [15:0]          span;
  logic [15:0]          beats;
  logic [7:0]           axlen;

  assign byte_addr = frag_addr_i[AddrWidth:1];
  // An odd start nibble drags in one extra byte at the front.
  assign bytes     = (15'(frag_addr_i[0]) + 15'(frag_nbs_i) + 15'd1) >> 1;
  assign off       = byte_addr[OffW-1:0];
  assign span      = 16'(off) + 16'(bytes) + 16'(DWB - 1);
  assign beats     = span >> OffW;
  assign axlen     = 8'(beats - 16'd1);

  // State
  logic                  ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
  ax_t                   ar_q, ar_d, aw_q, aw_d, ax_new;
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  info_t                 mem_q [InfoDepth];
  info_t                 info_new;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0]      fcnt_q, fcnt_d;

  logic ar_free, aw_free, slot_ok, cnt_ok, fifo_full;
  logic accept, acc_rd, acc_wr, pop;

  // Slot is reusable when empty or handing off its beat this cycle.
  assign ar_free   = !ar_valid_q || ar_ready_i;
  assign aw_free   = !aw_valid_q || aw_ready_i;
  assign slot_ok   = frag_is_load_i ? ar_free : aw_free;
  assign cnt_ok    = frag_is_load_i ? (rd_cnt_q < CntW'(MaxOutstanding))
                                    : (wr_cnt_q < CntW'(MaxOutstanding));
  assign fifo_full = (fcnt_q == FcntW'(InfoDepth));

  assign frag_ready_o = slot_ok && cnt_ok && !fifo_full;
  assign accept       = frag_valid_i && frag_ready_o;
  assign acc_rd       = accept && frag_is_load_i;
  assign acc_wr       = accept && !frag_is_load_i;
  assign pop          = info_valid_o && info_ready_i;

  assign ax_new   = '{addr: byte_addr, len: axlen, id: frag_id_i};
  assign info_new = '{off: off, nbs: frag_nbs_i, nib_odd: frag_addr_i[0],
                      last: frag_last_i, is_load: frag_is_load_i};

  always_comb begin
    ar_valid_d = ar_valid_q && !ar_ready_i;
    ar_d       = ar_q;
    aw_valid_d = aw_valid_q && !aw_ready_i;
    aw_d       = aw_q;
    if (acc_rd) begin
      ar_valid_d = 1'b1;
      ar_d       = ax_new;
    end
    if (acc_wr) begin
      aw_valid_d = 1'b1;
      aw_d       = ax_new;
    end
    // Counts are reserved at acceptance, released at completion.
    rd_cnt_d = cnt_next(rd_cnt_q, acc_rd, r_last_hs_i);
    wr_cnt_d = cnt_next(wr_cnt_q, acc_wr, b_hs_i);
    fcnt_d   = fcnt_q + FcntW'(accept) - FcntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      ar_q       <= '0;
      aw_q       <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      for (int i = 0; i < int'(InfoDepth); i++) mem_q[i] <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      aw_valid_q <= aw_valid_d;
      ar_q       <= ar_d;
      aw_q       <= aw_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      fcnt_q     <= fcnt_d;
      if (accept) begin
        mem_q[wr_ptr_q] <= info_new;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = ar_q.addr;
  assign ar_len_o   = ar_q.len;
  assign ar_id_o    = ar_q.id;
  assign ar_size_o  = ar_valid_q ? 3'(OffW) : 3'd0;
  assign ar_burst_o = ar_valid_q ? 2'b01 : 2'b00;
  assign aw_valid_o = aw_valid_q;
  assign aw_addr_o  = aw_q.addr;
  assign aw_len_o   = aw_q.len;
  assign aw_id_o    = aw_q.id;
  assign aw_size_o  = aw_valid_q ? 3'(OffW) : 3'd0;
  assign aw_burst_o = aw_valid_q ? 2'b01 : 2'b00;

  assign info_valid_o   = (fcnt_q != '0);
  assign info_off_o     = mem_q[rd_ptr_q].off;
  assign info_nbs_o     = mem_q[rd_ptr_q].nbs;
  assign info_nib_odd_o = mem_q[rd_ptr_q].nib_odd;
  assign info_last_o    = mem_q[rd_ptr_q].last;
  assign info_is_load_o = mem_q[rd_ptr_q].is_load;

  assign idle_o = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !ar_valid_q &&
                  !aw_valid_q && (fcnt_q == '0);

`ifndef SYNTHESIS
  logic [13:0] page_end;
  assign page_end = {1'b0, frag_addr_i[12:0]} + frag_nbs_i - 14'd1;

  a_nbs_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (frag_nbs_i != 14'd0) && (frag_nbs_i <= 14'd8192));
  a_no_page_cross: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (page_end < 14'd8192));
  a_beats_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (beats != 16'd0) && (beats <= 16'd256));
  a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_last_hs_i |-> (rd_cnt_q != '0));
  a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    b_hs_i |-> (wr_cnt_q != '0));
`endif

endmodule

// File: tb/tb_vlsu_txn_issuer.sv
module tb_vlsu_txn_issuer;

  logic        clk_i, rst_ni;
  logic        frag_valid_i, frag_ready_o;
  logic [64:0] frag_addr_i;
  logic [13:0] frag_nbs_i;
  logic        frag_is_load_i, frag_last_i;
  logic [3:0]  frag_id_i;
  logic        ar_valid_o, ar_ready_i, aw_valid_o, aw_ready_i;
  logic [63:0] ar_addr_o, aw_addr_o;
  logic [7:0]  ar_len_o, aw_len_o;
  logic [2:0]  ar_size_o, aw_size_o;
  logic [1:0]  ar_burst_o, aw_burst_o;
  logic [3:0]  ar_id_o, aw_id_o;
  logic        r_last_hs_i, b_hs_i;
  logic        info_valid_o, info_ready_i;
  logic [3:0]  info_off_o;
  logic [13:0] info_nbs_o;
  logic        info_nib_odd_o, info_last_o, info_is_load_o, idle_o;

  vlsu_txn_issuer #(.AddrWidth(64), .DataWidth(128), .IdWidth(4),
                    .MaxOutstanding(2), .InfoDepth(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
    .frag_addr_i(frag_addr_i), .frag_nbs_i(frag_nbs_i),
    .frag_is_load_i(frag_is_load_i), .frag_id_i(frag_id_i), .frag_last_i(frag_last_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o), .aw_id_o(aw_id_o),
    .r_last_hs_i(r_last_hs_i), .b_hs_i(b_hs_i),
    .info_valid_o(info_valid_o), .info_ready_i(info_ready_i),
    .info_off_o(info_off_o), .info_nbs_o(info_nbs_o), .info_nib_odd_o(info_nib_odd_o),
    .info_last_o(info_last_o), .info_is_load_o(info_is_load_o), .idle_o(idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [64:0] addr;
    logic [13:0] nbs;
    bit          ld;
    logic [3:0]  id;
    bit          last;
    logic [63:0] e_addr;
    logic [7:0]  e_len;
    logic [3:0]  e_off;
  } vec_t;

  typedef struct { logic [63:0] addr; logic [7:0] len; logic [3:0] id; } ax_e_t;
  typedef struct { logic [3:0] off; logic [13:0] nbs; bit odd; bit last; bit ld; } inf_e_t;

  ax_e_t  ar_exp[$], aw_exp[$];
  inf_e_t info_exp[$];
  int     tests = 0, fails = 0;
  vec_t   vecs[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic monitor();
    ax_e_t  e;
    inf_e_t f;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (ar_valid_o && ar_ready_i) begin
          if (ar_exp.size() == 0) timeout("ar_unexpected");
          else begin
            e = ar_exp.pop_front();
            chk("ar_beat", {ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o},
                {e.addr, e.len, 3'd4, 2'd1, e.id});
          end
        end
        if (aw_valid_o && aw_ready_i) begin
          if (aw_exp.size() == 0) timeout("aw_unexpected");
          else begin
            e = aw_exp.pop_front();
            chk("aw_beat", {aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o},
                {e.addr, e.len, 3'd4, 2'd1, e.id});
          end
        end
        if (info_valid_o && info_ready_i) begin
          if (info_exp.size() == 0) timeout("info_unexpected");
          else begin
            f = info_exp.pop_front();
            chk("info", {info_off_o, info_nbs_o, info_nib_odd_o, info_last_o, info_is_load_o},
                {f.off, f.nbs, f.odd, f.last, f.ld});
          end
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [64:0] a, input logic [13:0] n, input bit ld,
                      input logic [3:0] id, input bit last,
                      input logic [63:0] ea, input logic [7:0] el, input logic [3:0] eo);
    bit ok = 0;
    frag_addr_i = a; frag_nbs_i = n; frag_is_load_i = ld;
    frag_id_i = id; frag_last_i = last; frag_valid_i = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (frag_ready_o) begin ok = 1; break; end
    end
    if (ok) begin
      if (ld) ar_exp.push_back('{ea, el, id});
      else    aw_exp.push_back('{ea, el, id});
      info_exp.push_back('{eo, n, a[0], last, ld});
    end else timeout("send");
    @(posedge clk_i); #1;
    frag_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (ar_exp.size() == 0 && aw_exp.size() == 0 && info_exp.size() == 0) begin
        ok = 1; break;
      end
    end
    if (!ok) timeout("drain");
    @(posedge clk_i); #1;
  endtask

  task automatic pulse(input bit r, input bit b);
    r_last_hs_i = r; b_hs_i = b;
    @(posedge clk_i); #1;
    r_last_hs_i = 1'b0; b_hs_i = 1'b0;
  endtask

  function automatic void model(input logic [64:0] a, input logic [13:0] n,
                                output logic [63:0] ea, output logic [7:0] el,
                                output logic [3:0] eo);
    logic [64:0] first, lastb;
    first = a >> 1;
    lastb = (a + 65'(n) - 65'd1) >> 1;
    ea = first[63:0];
    el = 8'((lastb >> 4) - (first >> 4));
    eo = first[3:0];
  endfunction

  initial begin
    logic [64:0] ra;
    logic [13:0] rn;
    logic [63:0] ea;
    logic [7:0]  el;
    logic [3:0]  eo;
    int          room;

    vecs[0] = '{65'h21,   14'd7,    1, 4'h1, 1, 64'h10,   8'd0,   4'd0};
    vecs[1] = '{65'h1C,   14'd8,    0, 4'h2, 0, 64'hE,    8'd1,   4'd14};
    vecs[2] = '{65'h0,    14'd8192, 1, 4'h3, 0, 64'h0,    8'd255, 4'd0};
    vecs[3] = '{65'h3,    14'd1,    0, 4'h4, 1, 64'h1,    8'd0,   4'd1};
    vecs[4] = '{65'h1F,   14'd2,    1, 4'h5, 0, 64'hF,    8'd1,   4'd15};
    vecs[5] = '{65'h2001, 14'd8191, 0, 4'h6, 1, 64'h1000, 8'd255, 4'd0};
    vecs[6] = '{65'h1E,   14'd4,    1, 4'h7, 0, 64'hF,    8'd1,   4'd15};
    vecs[7] = '{65'h40,   14'd32,   1, 4'h8, 1, 64'h20,   8'd0,   4'd0};

    frag_valid_i = 0; frag_addr_i = '0; frag_nbs_i = '0; frag_is_load_i = 0;
    frag_id_i = '0; frag_last_i = 0; ar_ready_i = 0; aw_ready_i = 0;
    r_last_hs_i = 0; b_hs_i = 0; info_ready_i = 0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    fork monitor(); join_none
    #2;
    chk("rst_valids", {ar_valid_o, aw_valid_o, info_valid_o}, 3'b000);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_ready", frag_ready_o, 1'b1);
    chk("rst_payload", {ar_addr_o, ar_len_o, aw_addr_o, info_nbs_o}, '0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    ar_ready_i = 1; aw_ready_i = 1; info_ready_i = 1;

    // Table vectors, one at a time, completion returned afterwards.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].addr, vecs[i].nbs, vecs[i].ld, vecs[i].id, vecs[i].last,
           vecs[i].e_addr, vecs[i].e_len, vecs[i].e_off);
      drain();
      pulse(vecs[i].ld, !vecs[i].ld);
    end

    // Model-checked page-bounded fragments.
    for (int i = 0; i < 6; i++) begin
      ra = {49'd0, 16'($urandom_range(0, 65535))};
      room = 8192 - int'(ra[12:0]);
      rn = 14'($urandom_range(1, room));
      model(ra, rn, ea, el, eo);
      send(ra, rn, i[0], 4'(i), i[1], ea, el, eo);
      drain();
      pulse(i[0], !i[0]);
    end

    // AR stalled: payload holds; a store issues past it; descriptor order kept.
    ar_ready_i = 0;
    send(65'h21, 14'd7, 1, 4'h5, 0, 64'h10, 8'd0, 4'd0);
    send(65'h1C, 14'd8, 0, 4'h6, 1, 64'hE, 8'd1, 4'd14);
    repeat (4) begin
      @(negedge clk_i);
      chk("ar_hold", {ar_valid_o, ar_addr_o, ar_len_o, ar_id_o}, {1'b1, 64'h10, 8'd0, 4'h5});
    end
    chk("aw_indep", aw_exp.size(), 0);
    @(posedge clk_i); #1;
    ar_ready_i = 1;
    drain();
    pulse(1, 1);

    // Outstanding limit of 2 on the read side.
    send(65'h100, 14'd4, 1, 4'h1, 0, 64'h80, 8'd0, 4'd0);
    send(65'h200, 14'd4, 1, 4'h2, 0, 64'h100, 8'd0, 4'd0);
    frag_addr_i = 65'h300; frag_nbs_i = 14'd4; frag_is_load_i = 1;
    frag_id_i = 4'h3; frag_last_i = 1; frag_valid_i = 1;
    repeat (3) begin
      @(negedge clk_i);
      chk("limit_block", frag_ready_o, 1'b0);
    end
    @(posedge clk_i); #1;
    pulse(1, 0);
    @(negedge clk_i);
    chk("limit_free", frag_ready_o, 1'b1);
    ar_exp.push_back('{64'h180, 8'd0, 4'h3});
    info_exp.push_back('{4'd0, 14'd4, 1'b0, 1'b1, 1'b1});
    @(posedge clk_i); #1;
    frag_addr_i = 65'h400; frag_id_i = 4'h4;
    @(negedge clk_i);
    chk("limit_still_full", frag_ready_o, 1'b0);
    @(posedge clk_i); #1;
    frag_valid_i = 0;
    drain();
    pulse(1, 0);
    pulse(1, 0);
    @(negedge clk_i);
    chk("idle_after_limit", idle_o, 1'b1);
    @(posedge clk_i); #1;

    // Descriptor FIFO full, then asynchronous reset mid-burst.
    info_ready_i = 0;
    send(65'h300, 14'd2, 0, 4'h9, 0, 64'h180, 8'd0, 4'd0);
    send(65'h400, 14'd2, 1, 4'hA, 0, 64'h200, 8'd0, 4'd0);
    frag_addr_i = 65'h500; frag_nbs_i = 14'd2; frag_is_load_i = 0;
    frag_id_i = 4'hB; frag_valid_i = 1;
    @(negedge clk_i);
    chk("fifo_full_block", {frag_ready_o, info_valid_o}, 2'b01);
    chk("fifo_full_busy", idle_o, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_valids", {ar_valid_o, aw_valid_o, info_valid_o}, 3'b000);
    chk("async_rst_idle", idle_o, 1'b1);
    info_exp.delete();
    ar_exp.delete();
    aw_exp.delete();
    frag_valid_i = 0;
    info_ready_i = 1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Recovery after reset.
    send(65'h21, 14'd7, 1, 4'hC, 1, 64'h10, 8'd0, 4'd0);
    drain();
    pulse(1, 0);
    @(negedge clk_i);
    chk("final_idle", idle_o, 1'b1);
    chk("final_queues", ar_exp.size() + aw_exp.size() + info_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
